// File: rtl/ps_job_responder_if.sv
// PS command/interrupt handshake plus user-job launch/completion signals for one responder.
// The master side is the PS plus user logic; the slave side is the responder.
interface ps_job_responder_if #(
  parameter int unsigned CMD_W  = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_in;
  logic              clr_in;
  logic [CMD_W-1:0]  cmd_in;
  logic              decouple;
  logic              ack_out;
  logic              done_intr;
  logic [DATA_W-1:0] result_out;
  logic              job_start;
  logic [CMD_W-1:0]  job_cmd;
  logic              job_done;
  logic [DATA_W-1:0] job_result;

  modport master (
    output req_in, clr_in, cmd_in, decouple, job_done, job_result,
    input  ack_out, done_intr, result_out, job_start, job_cmd
  );

  modport slave (
    input  req_in, clr_in, cmd_in, decouple, job_done, job_result,
    output ack_out, done_intr, result_out, job_start, job_cmd
  );
endinterface

// File: rtl/ps_job_responder.sv
// PL-side responder: accepts a PS command on a synchronised request, runs a user job,
// returns its result (or an error word on timeout) and holds a level interrupt until cleared.
module ps_job_responder #(
  parameter int unsigned       CMD_W       = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       TIMEOUT_CYC = 1000000,
  parameter logic [DATA_W-1:0] ERR_WORD    = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              sys_clk0,
  input  logic              sys_reset,
  ps_job_responder_if.slave bus,
  output logic [31:0]       run_cycles,
  output logic              err_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] req_sync_q, clr_sync_q;
  logic                   req_s, clr_s;

  logic              armed_q, armed_d;
  logic              ack_q, ack_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [31:0]       run_q, run_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cnt_inc;
  logic              timeout_hit;

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign clr_s = clr_sync_q[SYNC_STAGES-1];

  // Saturating increment; the value it yields is the RUN-cycle count including this cycle.
  assign cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TIMEOUT_CYC);

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    ack_d    = ack_q;
    start_d  = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    run_d    = run_q;
    cnt_d    = cnt_q;

    // Re-arming and ack release follow the synchronised request in every state.
    if (!req_s) begin
      armed_d = 1'b1;
      ack_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (req_s && armed_q && !bus.decouple) begin
          state_d = StRun;
          armed_d = 1'b0;
          ack_d   = 1'b1;
          start_d = 1'b1;
          cmd_d   = bus.cmd_in;
          err_d   = 1'b0;
          cnt_d   = 32'd0;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // A completion in the timeout cycle still counts as a normal completion.
        if (bus.job_done) begin
          result_d = bus.job_result;
          run_d    = cnt_inc;
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (timeout_hit) begin
          result_d = ERR_WORD;
          err_d    = 1'b1;
          run_d    = TIMEOUT_CYC;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (clr_s) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk0) begin
    if (sys_reset) begin
      state_q    <= StIdle;
      req_sync_q <= '0;
      clr_sync_q <= '0;
      armed_q    <= 1'b0;
      ack_q      <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cmd_q      <= '0;
      result_q   <= '0;
      run_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.req_in};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], bus.clr_in};
      armed_q    <= armed_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cmd_q      <= cmd_d;
      result_q   <= result_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ack_out    = ack_q;
  assign bus.done_intr  = done_q;
  assign bus.result_out = result_q;
  assign bus.job_start  = start_q;
  assign bus.job_cmd    = cmd_q;
  assign run_cycles     = run_q;
  assign err_timeout    = err_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_ps_job_responder.sv
// Scoreboard bench for ps_job_responder: drivers queue expected launches/completions,
// a negedge monitor checks them as the responder presents them.
module tb_ps_job_responder;

  localparam int unsigned T   = 50;
  localparam int unsigned SS  = 2;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] result;
    logic [31:0] run;
    logic        err;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] run_cycles;
  logic        err_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] start_q[$];
  done_t       done_q[$];
  logic        done_prev;
  logic [31:0] mon_cmd;
  done_t       mon_done;
  done_t       last_done;

  ps_job_responder_if #(.CMD_W(32), .DATA_W(32)) bus ();

  ps_job_responder #(
    .CMD_W      (32),
    .DATA_W     (32),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYC(T),
    .ERR_WORD   (ERR)
  ) dut (
    .sys_clk0   (clk),
    .sys_reset  (rst),
    .bus        (bus),
    .run_cycles (run_cycles),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a job completes normally iff its done strobe lands within the timeout window.
  function automatic done_t model(input int unsigned delay, input logic [31:0] res);
    done_t d;
    if (delay != 0 && delay <= T) begin
      d.result = res;
      d.run    = delay;
      d.err    = 1'b0;
    end else begin
      d.result = ERR;
      d.run    = T;
      d.err    = 1'b1;
    end
    return d;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      if (bus.job_start) begin
        if (start_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_job_start: got job_start=1 expected no launch");
        end else begin
          mon_cmd = start_q.pop_front();
          chk("job_cmd", bus.job_cmd, mon_cmd);
        end
      end
      if (bus.done_intr && !done_prev) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done_intr: got done_intr=1 expected no completion");
        end else begin
          mon_done = done_q.pop_front();
          chk("result_out", bus.result_out, mon_done.result);
          chk("run_cycles", run_cycles, mon_done.run);
          chk("err_timeout", err_timeout, mon_done.err);
        end
      end
      done_prev <= bus.done_intr;
    end
  end

  // Raise req with cmd and wait for ack; returns in RUN cycle 1.
  task automatic request(input logic [31:0] cmd, input bit hold);
    int n;
    start_q.push_back(cmd);
    bus.cmd_in = cmd;
    bus.req_in = 1'b1;
    n = 0;
    while (!bus.ack_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_latency", n, SS + 1);
    chk("job_start_with_ack", bus.job_start, 1);
    if (!hold) bus.req_in = 1'b0;
  endtask

  task automatic finish(input int unsigned delay, input logic [31:0] res, input bit hold,
                        input bit rand_dec);
    int n;
    last_done = model(delay, res);
    done_q.push_back(last_done);
    for (int c = 1; c <= int'(T) + 20; c++) begin
      bus.job_done   = (c == int'(delay));
      bus.job_result = (c == int'(delay)) ? res : $urandom();
      if (rand_dec) bus.decouple = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.job_done = 1'b0;
    bus.decouple = 1'b0;
    chk("done_intr_held", bus.done_intr, 1);
    bus.clr_in = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    bus.clr_in = 1'b0;
    chk("clear_to_idle", busy, 0);
    chk("done_intr_cleared", bus.done_intr, 0);
    chk("result_kept", bus.result_out, last_done.result);
    chk("run_cycles_kept", run_cycles, last_done.run);
    repeat (SS + 2) @(posedge clk);
    #1;
    chk("ack_after_job", bus.ack_out, hold);
  endtask

  initial begin
    int viol;
    int n;
    rst            = 1'b1;
    bus.req_in     = 1'b0;
    bus.clr_in     = 1'b0;
    bus.cmd_in     = '0;
    bus.decouple   = 1'b0;
    bus.job_done   = 1'b0;
    bus.job_result = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.ack_out, bus.done_intr, bus.result_out, bus.job_start,
                          err_timeout, busy}, 0);
    chk("reset_job_cmd", bus.job_cmd, 0);
    chk("reset_run_cycles", run_cycles, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Nominal job
    request(32'h1234_5678, 1'b0);
    finish(10, 32'hCAFE_0001, 1'b0, 1'b0);

    // Request held through DONE and clear: no retrigger until it drops and rises again
    request(32'h0BAD_F00D, 1'b1);
    finish(20, 32'h0000_1111, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("held_req_no_retrigger", busy, 0);
    bus.req_in = 1'b0;
    n = 0;
    while (bus.ack_out && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_drops_with_req", bus.ack_out, 0);
    repeat (SS + 1) @(posedge clk);
    #1;
    request(32'h5555_AAAA, 1'b0);
    finish(3, 32'h7777_0003, 1'b0, 1'b0);

    // Timeout, with a late job_done that must be ignored
    request(32'hA0A0_0003, 1'b0);
    finish(65, 32'h1111_2222, 1'b0, 1'b0);
    chk("timeout_err_flag", err_timeout, 1);

    // job_done exactly on the timeout cycle wins
    request(32'hA0A0_0004, 1'b0);
    finish(T, 32'h3333_4444, 1'b0, 1'b0);

    // Decouple holds off a pending request
    start_q.push_back(32'hDEC0_0005);
    bus.cmd_in   = 32'hDEC0_0005;
    bus.decouple = 1'b1;
    bus.req_in   = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ack_out || busy) viol++;
    end
    chk("decouple_blocks", viol, 0);
    bus.decouple = 1'b0;
    @(posedge clk); #1;
    chk("decouple_release_ack", bus.ack_out, 1);
    chk("decouple_release_start", bus.job_start, 1);
    bus.req_in = 1'b0;
    finish(7, 32'h0D0D_0007, 1'b0, 1'b0);

    // Reset in RUN cycle 5; a later job_done must not complete anything
    request(32'hEEEE_0006, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_reset_outputs", {bus.ack_out, bus.done_intr, bus.result_out, bus.job_start,
                                 err_timeout, busy}, 0);
    chk("midrun_reset_job_cmd", bus.job_cmd, 0);
    chk("midrun_reset_run_cycles", run_cycles, 0);
    bus.job_done   = 1'b1;
    bus.job_result = 32'h9999_9999;
    @(posedge clk); #1;
    bus.job_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_reset", {bus.done_intr, busy}, 0);
    repeat (SS + 2) @(posedge clk);
    #1;

    // Randomised jobs with decouple toggling during the job
    for (int j = 0; j < 10; j++) begin
      int unsigned d;
      d = $urandom_range(0, 7) == 0 ? T : $urandom_range(1, 62);
      request($urandom(), 1'b0);
      finish(d, $urandom(), 1'b0, 1'b1);
    end

    chk("start_queue_drained", start_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
